aes_key_expand: RTL

Iterative AES-128 key schedule producing round keys 0..10 in sequence, one per accepted handshake, for the AddRoundKey stage of the cipher datapath. It sits directly upstream of AddRoundKey. Each round key is emitted in text order (FIPS-197 words w[4r]..w[4r+3] concatenated, byte 0 in bits [127:120]); AddRoundKey performs the column/row transposition itself. Expansion is on the fly, one round per cycle, with backpressure from the consumer. No key table is stored.

---
 rtl/aes_key_expand.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : aes_key_expand (with aes_sbox)                                    |
// | Brief  : Iterative AES-128 key schedule, one round key per handshake.      |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Forward S-box, index 0 is the leftmost entry.
    localparam logic [0:255][7:0] c_SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = c_SBOX[i_byte];

endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         round_key_valid,
    input  logic         round_key_ready,
    output logic         done
);

    localparam logic       c_IDLE     = 1'b0;
    localparam logic       c_EMIT     = 1'b1;
    localparam logic [3:0] c_LAST_IDX = 4'd10;

    logic         r_state;
    logic [127:0] r_round_key;
    logic [3:0]   r_round_idx;
    logic [7:0]   r_rcon;
    logic         r_done;

    logic         w_state_next;
    logic [127:0] w_key_next;
    logic [3:0]   w_idx_next;
    logic [7:0]   w_rcon_next;
    logic         w_done_next;

    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    logic [127:0] w_key_calc;
    logic [7:0]   w_rcon_xtime;

    // RotWord moves the most significant byte of w3 to the bottom.
    assign w_rot = {r_round_key[23:0], r_round_key[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_t        = w_sub ^ {r_rcon, 24'h0};
    assign w_w0       = r_round_key[127:96] ^ w_t;
    assign w_w1       = r_round_key[95:64]  ^ w_w0;
    assign w_w2       = r_round_key[63:32]  ^ w_w1;
    assign w_w3       = r_round_key[31:0]   ^ w_w2;
    assign w_key_calc = {w_w0, w_w1, w_w2, w_w3};

    assign w_rcon_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_comb begin
        w_state_next = r_state;
        w_key_next   = r_round_key;
        w_idx_next   = r_round_idx;
        w_rcon_next  = r_rcon;
        w_done_next  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = c_EMIT;
                    w_key_next   = key_in;
                    w_idx_next   = 4'd0;
                    w_rcon_next  = 8'h01;
                end
            end
            c_EMIT: begin
                if (round_key_ready) begin
                    if (r_round_idx == c_LAST_IDX) begin
                        w_state_next = c_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_key_next  = w_key_calc;
                        w_idx_next  = r_round_idx + 4'd1;
                        w_rcon_next = w_rcon_xtime;
                    end
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_round_key <= 128'h0;
            r_round_idx <= 4'd0;
            r_rcon      <= 8'h01;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_round_key <= w_key_next;
            r_round_idx <= w_idx_next;
            r_rcon      <= w_rcon_next;
            r_done      <= w_done_next;
        end
    end

    assign key_ready       = (r_state == c_IDLE);
    assign round_key_valid = (r_state == c_EMIT);
    assign round_key       = r_round_key;
    assign round_idx       = r_round_idx;
    assign done            = r_done;

endmodule
`default_nettype wire
